// File: rtl/rv_pkg.sv
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared RV32 constants: ALU control encodings, opcode and
//                funct constants, and the fetch/decode FSM state type.
//                Used by instr_fetch_decode, rtype_decoder and the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    // ALU operation select shared with the datapath ALU
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_t;

    // Fetch/decode sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fsm_state_t;

    localparam logic [6:0]  c_OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0]  c_OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_FUNCT7_BASE   = 7'h00;
    localparam logic [6:0]  c_FUNCT7_ALT    = 7'h20;
    localparam logic [2:0]  c_FUNCT3_BEQ    = 3'b000;
    localparam logic [2:0]  c_FUNCT3_BNE    = 3'b001;
    // addi x0,x0,0 : a NOP whose register fields are all zero
    localparam logic [31:0] c_IR_RESET      = 32'h0000_0013;

endpackage : rv_pkg

`default_nettype wire

// File: rtl/rtype_decoder.sv
// ============================================================================
//  Module      : rtype_decoder
//  Description : Combinational R-type decoder. Maps {funct7[5], funct3} of an
//                OP instruction to the ALU control code and flags whether the
//                funct7/funct3 combination is a legal RV32I R-type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import rv_pkg::*;

module rtype_decoder (
    input  logic [31:0] ir,
    output logic [3:0]  alu_control,
    output logic        legal
);

    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    logic       w_unused_fields;

    assign w_funct7 = ir[31:25];
    assign w_funct3 = ir[14:12];

    // Register-number fields are decoded by the parent, not here
    assign w_unused_fields = &{1'b0, ir[24:15], ir[11:7]};

    // Decode ALU operation; anything outside the base/alt funct7 set is illegal
    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b0;
        if (ir[6:0] == c_OPCODE_RTYPE) begin
            if (w_funct7 == c_FUNCT7_BASE) begin
                legal = 1'b1;
                case (w_funct3)
                    3'b000:  alu_control = ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end else if (w_funct7 == c_FUNCT7_ALT) begin
                // Only ADD->SUB and SRL->SRA have an alternate form
                if (w_funct3 == 3'b000) begin
                    legal       = 1'b1;
                    alu_control = ALU_SUB;
                end else if (w_funct3 == 3'b101) begin
                    legal       = 1'b1;
                    alu_control = ALU_SRA;
                end
            end
        end
    end

endmodule : rtype_decoder

`default_nettype wire

// File: rtl/instr_fetch_decode.sv
// ============================================================================
//  Module      : instr_fetch_decode
//  Description : Multi-cycle instruction fetch / decode sequencer. Fetches a
//                word from instruction memory (IDLE -> FETCH -> EXEC), holds
//                it in IR, drives register numbers and ALU control to the
//                datapath, and counts retired instructions.
//                Optional macro BRANCH_EN adds BEQ/BNE support using the
//                datapath zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import rv_pkg::*;

module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  read_reg_num1,
    output logic [4:0]  read_reg_num2,
    output logic [4:0]  write_reg,
    output logic [3:0]  alu_control,
    output logic        regwrite,
    input  logic        zero_flag,
    output logic        illegal_instr,
    output logic [31:0] retired_count
);

    localparam logic [31:0] c_PC_STEP = 32'(PC_STEP);

    fsm_state_t  r_state;
    fsm_state_t  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_retired;
    logic [31:0] w_next_pc;
    logic [3:0]  w_rtype_alu;
    logic        w_rtype_legal;

`ifdef BRANCH_EN
    logic        w_is_branch;
    logic        w_branch_taken;
    logic [31:0] w_b_imm;

    // BEQ/BNE differ only in funct3[0]; taken when zero flag matches
    assign w_is_branch    = (r_ir[6:0] == c_OPCODE_BRANCH) &&
                            ((r_ir[14:12] == c_FUNCT3_BEQ) || (r_ir[14:12] == c_FUNCT3_BNE));
    assign w_branch_taken = r_ir[12] ? ~zero_flag : zero_flag;
    assign w_b_imm        = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
`else
    logic w_unused_zero;
    assign w_unused_zero = &{1'b0, zero_flag};
`endif

    rtype_decoder u_rtype_decoder (
        .ir          (r_ir),
        .alu_control (w_rtype_alu),
        .legal       (w_rtype_legal)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a fetch once requested always runs through EXEC
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (run)      w_next_state = ST_FETCH;
            ST_FETCH: if (imem_ack) w_next_state = ST_EXEC;
            ST_EXEC:  w_next_state = run ? ST_FETCH : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // PC, IR and retired counter; IR loads only on the ack of an active fetch
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= c_IR_RESET;
            r_retired <= 32'd0;
        end else begin
            if ((r_state == ST_FETCH) && imem_ack) begin
                r_ir <= imem_rdata;
            end
            if (r_state == ST_EXEC) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // Execute-stage controls, forced to neutral values outside EXEC
    always_comb begin
        alu_control   = ALU_ADD;
        regwrite      = 1'b0;
        illegal_instr = 1'b0;
        w_next_pc     = r_pc + c_PC_STEP;
        if (r_state == ST_EXEC) begin
            if (w_rtype_legal) begin
                alu_control = w_rtype_alu;
                regwrite    = (r_ir[11:7] != 5'd0);
            end
`ifdef BRANCH_EN
            else if (w_is_branch) begin
                alu_control = ALU_SUB;
                if (w_branch_taken) begin
                    w_next_pc = r_pc + w_b_imm;
                end
            end
`endif
            else begin
                illegal_instr = 1'b1;
            end
        end
    end

    assign imem_req      = (r_state == ST_FETCH);
    assign imem_addr     = r_pc;
    assign read_reg_num1 = r_ir[19:15];
    assign read_reg_num2 = r_ir[24:20];
    assign write_reg     = r_ir[11:7];
    assign retired_count = r_retired;

endmodule : instr_fetch_decode

`default_nettype wire

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 4, meaning the PC increment per sequential instruction.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port run, input, 1, a level that permits leaving IDLE.
REQ-006 SHALL have ports imem_req (output, 1) and imem_addr (output, 32), the instruction-memory request and word address.
REQ-007 SHALL have ports imem_ack (input, 1) and imem_rdata (input, 32): the fetch completes when imem_ack is high, and imem_rdata is valid in that same cycle.
REQ-008 SHALL have outputs read_reg_num1 (5), read_reg_num2 (5), write_reg (5), alu_control (4) and regwrite (1), which drive the datapath inputs of the same names.
REQ-009 SHALL have port zero_flag, input, 1, the datapath ALU zero flag.
REQ-010 SHALL have outputs illegal_instr (1), a one-cycle pulse, and retired_count (32), the count of completed instructions.

Function
REQ-011 SHALL implement the FSM IDLE -> FETCH -> EXEC -> FETCH, and SHALL return to IDLE from EXEC when run is low.
REQ-012 In IDLE, SHALL hold imem_req and regwrite at 0 and go to FETCH on the first cycle run is high.
REQ-013 In FETCH, SHALL hold imem_req at 1 and imem_addr at PC stable until the ack cycle; on imem_ack, SHALL capture imem_rdata into IR and go to EXEC.
REQ-014 SHALL drop imem_req in the cycle after the ack.
REQ-015 SHALL spend exactly one cycle in EXEC, so that minimum latency is 2 cycles per instruction with a zero-wait-state memory.
REQ-016 Decode field mapping from IR: read_reg_num1=IR[19:15], read_reg_num2=IR[24:20], write_reg=IR[11:7].
REQ-017 Decode outputs SHALL be registered from IR and valid throughout EXEC.
REQ-018 For opcode 7'b0110011, SHALL set alu_control from {funct7[5], funct3} using the package encoding: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-019 Any R-type funct7 other than 7'h00, or 7'h20 with ADD/SRL, SHALL be treated as illegal.
REQ-020 regwrite SHALL be 1 only in EXEC, only for a legal R-type, and only when write_reg != 0.
REQ-021 An illegal instruction SHALL pulse illegal_instr for its EXEC cycle with regwrite=0, and SHALL still advance PC by PC_STEP.
REQ-022 In EXEC, SHALL update PC <= PC + PC_STEP with 32-bit wrap-around, so 32'hFFFF_FFFC becomes 32'h0000_0000.
REQ-023 retired_count SHALL increment by 1 at the end of every EXEC, legal or illegal, and SHALL wrap modulo 2^32.
REQ-024 Outside EXEC, alu_control SHALL be ADD and illegal_instr SHALL be 0.
REQ-025 A run deassertion during FETCH SHALL take effect only after the pending fetch and its EXEC complete, with no abandoned request.

Reset
REQ-026 On reset high at a clock edge, SHALL set state=IDLE, PC=RESET_PC, IR=32'h0000_0013, retired_count=0, and all outputs to 0 (alu_control=ADD), regardless of current state.
REQ-027 SHALL honour reset mid-FETCH, so that imem_req is 0 in the cycle after the reset edge and any late imem_ack in IDLE is ignored.

Configuration
REQ-028 With BRANCH_EN defined, opcode 7'b1100011 with funct3 000 (BEQ) or 001 (BNE) SHALL be legal: in EXEC, alu_control=SUB, regwrite=0, and zero_flag is sampled at the EXEC edge.
REQ-029 With BRANCH_EN defined and the branch taken, PC <= PC + sign-extended B-immediate; otherwise PC <= PC + PC_STEP.
REQ-030 Without BRANCH_EN, SHALL treat opcode 7'b1100011 as illegal per REQ-021, and SHALL leave zero_flag unused.

Structure
REQ-031 SHALL place the ALU control encodings, opcode constants, and FSM state typedef in shared package rv_pkg, which is also used by the ALU.
REQ-032 SHALL contain one combinational sub-module, rtype_decoder (IR in; alu_control, legal out), with the PC, IR, FSM and counter kept in instr_fetch_decode.

Verification
REQ-033 Reset, then run=1 with zero-wait memory returning 32'h002081B3 (add x3,x1,x2) -> imem_addr=0, then EXEC with rs1=1, rs2=2, rd=3, ALU=ADD, regwrite=1, next imem_addr=4.
REQ-034 Fetch of 32'h407302B3 with imem_ack delayed 3 cycles -> imem_req held 4 cycles at a stable address, then ALU=SUB, rd=5, retired_count=1.
REQ-035 Fetch of 32'h00000033 (add x0,x0,x0) -> regwrite=0, no illegal_instr; fetch of 32'hFFFFFFFF -> illegal_instr pulses 1 cycle, regwrite=0, PC+4.
REQ-036 With BRANCH_EN, fetch 32'h00208463 (beq x1,x2,+8) at PC=0x10 with zero_flag=1 -> next imem_addr=0x18; with zero_flag=0 -> next imem_addr=0x14.
REQ-037 With RESET_PC=32'hFFFF_FFFC, one legal R-type instruction -> next imem_addr=0.
REQ-038 Reset asserted in the second FETCH wait cycle -> imem_req=0 and PC=RESET_PC next cycle, and a following ack does not change state.
